// File: rtl/cpu_dump_pkg.sv
// Shared types and frame layout for the CPU state dumper.
// TRACE_CHECKSUM_EN adds a trailing XOR checksum word to every frame.
package cpu_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    REGS,
    MEM,
`ifdef TRACE_CHECKSUM_EN
    CHK,
`endif
    DONE
  } state_t;

  // Width of the frame word position counter.
  localparam int POS_W = 7;

  // Frame geometry for the standard RV32 configuration.
  localparam int DEF_NUM_REGS      = 32;
  localparam int DEF_NUM_MEM_WORDS = 8;
  localparam int HDR_WORDS         = 4;

  localparam int OFF_CYC   = 0;
  localparam int OFF_STALL = 1;
  localparam int OFF_FLUSH = 2;
  localparam int OFF_PC    = 3;
  localparam int OFF_REGS  = 4;
  localparam int OFF_MEM   = OFF_REGS + DEF_NUM_REGS;

`ifdef TRACE_CHECKSUM_EN
  localparam int CHK_WORDS = 1;
`else
  localparam int CHK_WORDS = 0;
`endif

  localparam int FRAME_WORDS = OFF_MEM + DEF_NUM_MEM_WORDS + CHK_WORDS;

endpackage

// File: rtl/dump_counter.sv
// Saturating event counter: advances while enabled, sticks at all-ones.
module dump_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Count enabled cycles, holding at the maximum instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     cnt_o <= '0;
    else if (en_i) cnt_o <= sat_inc(cnt_o);
  end

endmodule

// File: rtl/cpu_state_dumper.sv
// Streams a snapshot of CPU architectural state over a valid/ready word port.
// Frame: cycle/stall/flush counters, PC, x0..xN, data memory words.
// Define TRACE_CHECKSUM_EN to append an XOR checksum of all frame words.
module cpu_state_dumper
  import cpu_dump_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 8,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      pc_i,
  input  logic             snap_i,
  output logic [4:0]       reg_addr_o,
  input  logic [31:0]      reg_data_i,
  output logic [31:0]      mem_addr_o,
  input  logic [31:0]      mem_data_i,
  output logic [CNT_W-1:0] dout_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [POS_W-1:0] P_CYC   = POS_W'(OFF_CYC);
  localparam logic [POS_W-1:0] P_STALL = POS_W'(OFF_STALL);
  localparam logic [POS_W-1:0] P_FLUSH = POS_W'(OFF_FLUSH);
  localparam logic [POS_W-1:0] P_PC    = POS_W'(OFF_PC);
  localparam logic [POS_W-1:0] P_HDR   = POS_W'(HDR_WORDS);
  localparam logic [POS_W-1:0] P_REGS  = POS_W'(OFF_REGS);
  localparam logic [POS_W-1:0] P_MEM   = POS_W'(OFF_MEM + NUM_REGS - DEF_NUM_REGS);
  localparam logic [POS_W-1:0] P_CHK   = POS_W'(OFF_MEM + NUM_REGS - DEF_NUM_REGS + NUM_MEM_WORDS);
  localparam logic [POS_W-1:0] P_END   = POS_W'(FRAME_WORDS + NUM_REGS - DEF_NUM_REGS
                                                + NUM_MEM_WORDS - DEF_NUM_MEM_WORDS);

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d, np, mem_idx;
  logic [CNT_W-1:0]   dout_q, dout_d, load_word;
  logic [CNT_W-1:0]   cyc_cnt, stall_cnt, flush_cnt;
  logic [CNT_W-1:0]   stall_frz, flush_frz;
  logic [31:0]        pc_frz;
  logic               streaming, snap_take;
`ifdef TRACE_CHECKSUM_EN
  logic [CNT_W-1:0]   chk_q;
`endif

  dump_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(start_i), .cnt_o(cyc_cnt)
  );
  dump_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(start_i & stall_i), .cnt_o(stall_cnt)
  );
  dump_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(start_i & flush_i), .cnt_o(flush_cnt)
  );

  // pos_q is the frame position of the word in dout_o; np is the next one to load.
  assign np        = pos_q + POS_W'(1);
  assign mem_idx   = np - P_MEM;
  assign streaming = (state_q != IDLE) && (state_q != DONE);
  assign snap_take = (state_q == IDLE) && snap_i;

  assign valid_o = streaming;
  assign busy_o  = streaming;
  assign done_o  = (state_q == DONE);
  assign dout_o  = dout_q;

  // Read ports point at the word that the next handshake will load.
  assign reg_addr_o = (streaming && np >= P_REGS && np < P_MEM) ? 5'(np - P_REGS) : 5'd0;
  assign mem_addr_o = (streaming && np >= P_MEM && np < P_CHK) ? (32'(mem_idx) << 2) : 32'd0;

  // Select the word that belongs at frame position np.
  always_comb begin
    load_word = '0;
    if (np == P_STALL)     load_word = stall_frz;
    else if (np == P_FLUSH) load_word = flush_frz;
    else if (np == P_PC)    load_word = CNT_W'(pc_frz);
    else if (np < P_MEM)    load_word = CNT_W'(reg_data_i);
    else if (np < P_CHK)    load_word = CNT_W'(mem_data_i);
`ifdef TRACE_CHECKSUM_EN
    else                    load_word = chk_q ^ dout_q;
`endif
  end

  // Next-state logic: advance one frame word per accepted handshake.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (snap_i) begin
          state_d = HDR;
          pos_d   = P_CYC;
          dout_d  = cyc_cnt;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        if (ready_i) begin
          pos_d = np;
          if (np == P_END) begin
            state_d = DONE;
          end else begin
            dout_d = load_word;
            if (np < P_HDR)      state_d = HDR;
            else if (np < P_MEM) state_d = REGS;
            else if (np < P_CHK) state_d = MEM;
`ifdef TRACE_CHECKSUM_EN
            else                 state_d = CHK;
`endif
          end
        end
      end
    endcase
  end

  // Control and output word registers; reset abandons any frame in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pos_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dout_q  <= dout_d;
    end
  end

  // Freeze the header values seen at the snapshot edge.
  always_ff @(posedge clk_i) begin
    if (snap_take) begin
      stall_frz <= stall_cnt;
      flush_frz <= flush_cnt;
      pc_frz    <= pc_i;
    end
  end

`ifdef TRACE_CHECKSUM_EN
  // Accumulate the XOR of every word as it is accepted.
  always_ff @(posedge clk_i) begin
    if (snap_take)                chk_q <= '0;
    else if (streaming && ready_i) chk_q <= chk_q ^ dout_q;
  end
`endif

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Self-checking bench for cpu_state_dumper: table-driven frames plus reset
// and saturation sequences.
module tb_cpu_state_dumper;

`ifdef TRACE_CHECKSUM_EN
  localparam int FLEN = 45;
`else
  localparam int FLEN = 44;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0, snap_i = 1'b0, ready_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_i, mem_addr_o, mem_data_i, dout_o;
  logic        valid_o, busy_o, done_o;
  logic        sat_en = 1'b0;
  logic [2:0]  sat_cnt;

  logic [31:0] rf [32];
  logic [31:0] dm [8];

  always #5 clk_i = ~clk_i;

  assign reg_data_i = rf[reg_addr_o];
  assign mem_data_i = (mem_addr_o < 32'd32) ? dm[mem_addr_o[4:2]] : 32'hBAD0_0000;

  cpu_state_dumper dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .flush_i(flush_i), .pc_i(pc_i), .snap_i(snap_i), .reg_addr_o(reg_addr_o),
    .reg_data_i(reg_data_i), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .dout_o(dout_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o),
    .done_o(done_o)
  );

  dump_counter #(.CNT_W(3)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(sat_en), .cnt_o(sat_cnt)
  );

  typedef struct {
    int          ncyc;
    int          nstall;
    int          nflush;
    logic [31:0] pc;
    int          rmode;
    int          snap_at;
    logic [31:0] e_cyc;
    logic [31:0] e_stall;
    logic [31:0] e_flush;
  } vec_t;

  vec_t        vt [4];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rx  [64];
  logic [31:0] exp_w [64];
  int          nrx, ndone, nvalid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; start_i = 0; stall_i = 0; flush_i = 0; snap_i = 0; ready_i = 0; pc_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic load_state(input int v);
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(v << 16) + 32'(i * 3);
    rf[0] = 32'd0; rf[8] = 32'd5; rf[31] = 32'hFFFF_FFFF;
    for (int j = 0; j < 8; j++) dm[j] = 32'hA500_0000 | 32'(v << 12) | 32'(j * 4);
    dm[0] = 32'h0000_0005;  // bytes 05 00 00 00
  endtask

  task automatic run_counters(input int ncyc, input int nstall, input int nflush);
    for (int i = 0; i < ncyc; i++) begin
      start_i = 1'b1; stall_i = (i < nstall); flush_i = (i < nflush);
      @(negedge clk_i);
    end
    start_i = 0; stall_i = 0; flush_i = 0;
  endtask

  task automatic snap(input logic [31:0] pc);
    pc_i = pc; snap_i = 1'b1;
    @(negedge clk_i);
    snap_i = 1'b0;
  endtask

  task automatic collect(input int rmode, input int snap_at);
    logic        prev_hold = 1'b0;
    logic [31:0] prev_dout = '0;
    int          tail = 0;
    nrx = 0; ndone = 0; nvalid = 0;
    for (int c = 0; c < 400; c++) begin
      case (rmode)
        0:       ready_i = 1'b1;
        1:       ready_i = (c % 2 == 0);
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      snap_i = (snap_at >= 0 && nrx == snap_at);
      if (prev_hold) chk("dout_hold", dout_o, prev_dout);
      if (done_o) begin
        ndone++;
        chk("valid_at_done", 32'(valid_o), 32'd0);
      end
      if (ndone > 0) begin
        tail++;
        if (tail > 1) chk("idle_after_done", {30'd0, busy_o, valid_o}, 32'd0);
        if (tail >= 4) break;
      end else begin
        chk("busy_in_frame", 32'(busy_o), 32'd1);
      end
      if (valid_o) begin
        nvalid++;
        if (ready_i && nrx < 64) begin rx[nrx] = dout_o; nrx++; end
      end
      prev_hold = valid_o & ~ready_i;
      prev_dout = dout_o;
      @(negedge clk_i);
    end
    snap_i = 1'b0; ready_i = 1'b0;
    chk("words_accepted", 32'(nrx), 32'(FLEN));
    chk("done_pulses", 32'(ndone), 32'd1);
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    logic [31:0] x = '0;
    exp_w[0] = v.e_cyc; exp_w[1] = v.e_stall; exp_w[2] = v.e_flush; exp_w[3] = v.pc;
    for (int i = 0; i < 32; i++) exp_w[4 + i] = rf[i];
    for (int j = 0; j < 8; j++) exp_w[36 + j] = dm[j];
    for (int i = 0; i < 44; i++) x ^= exp_w[i];
    exp_w[44] = x;
    for (int i = 0; i < FLEN && i < nrx; i++)
      chk($sformatf("%s_word%0d", tag, i), rx[i], exp_w[i]);
  endtask

  initial begin
    vt[0] = '{10, 3, 2, 32'h0000_0028, 0, -1, 32'd10, 32'd3, 32'd2};
    vt[1] = '{7, 0, 7, 32'hDEAD_BEEC, 1, -1, 32'd7, 32'd0, 32'd7};
    vt[2] = '{0, 0, 0, 32'h0000_0000, 2, 20, 32'd0, 32'd0, 32'd0};
    vt[3] = '{25, 25, 1, 32'h0000_1234, 1, 20, 32'd25, 32'd25, 32'd1};
    load_state(0);

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_dout", dout_o, 32'd0);
    chk("rst_reg_addr", 32'(reg_addr_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    rst_i = 1'b0;

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      load_state(v);
      do_reset();
      run_counters(vt[v].ncyc, vt[v].nstall, vt[v].nflush);
      snap(vt[v].pc);
      collect(vt[v].rmode, vt[v].snap_at);
      if (vt[v].rmode == 0) chk("consecutive_valid", 32'(nvalid), 32'(FLEN));
      check_frame($sformatf("v%0d", v), vt[v]);
      if (v == 0) begin
        chk("x8_word12", rx[12], 32'd5);
        chk("x31_word35", rx[35], 32'hFFFF_FFFF);
        chk("mem0_word36", rx[36], 32'd5);
      end
    end

    // Reset in the middle of a frame
    load_state(1);
    do_reset();
    run_counters(4, 1, 1);
    snap(32'h40);
    ready_i = 1'b1;
    repeat (15) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_dout", dout_o, 32'd0);
    @(negedge clk_i);
    ready_i = 1'b0;
    rst_i = 1'b0;
    chk("midrst_no_done", 32'(done_o), 32'd0);
    run_counters(1, 0, 0);
    snap(32'h44);
    collect(0, -1);
    check_frame("after_rst", '{1, 0, 0, 32'h44, 0, -1, 32'd1, 32'd0, 32'd0});

    // Counter saturation on a narrow instance
    do_reset();
    chk("sat_reset", 32'(sat_cnt), 32'd0);
    sat_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_i);
      chk($sformatf("sat_step%0d", i), 32'(sat_cnt), (i < 7) ? 32'(i) : 32'd7);
    end
    sat_en = 1'b0;
    @(negedge clk_i);
    chk("sat_hold", 32'(sat_cnt), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
